// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch unit.
//   XLEN / ILEN     : address and instruction widths
//   NOP_IR          : instruction value presented when no instruction is valid
//   fetch_state_t   : fetch controller states
//   fetch_entry_t   : one instruction-queue entry {IR, PC}
//   align_word()    : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_IR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] ir;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and imem.
//   imem_req    : fetch request valid                     (master -> slave)
//   imem_addr   : word-aligned fetch address              (master -> slave)
//   imem_gnt    : request accepted this cycle             (slave -> master)
//   imem_rvalid : response valid, returned in request order (slave -> master)
//   imem_rdata  : instruction word                        (slave -> master)
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
    import if_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_inst_fifo.sv
// -----------------------------------------------------------------------------
// if_inst_fifo
// Small synchronous FIFO with a combinational head (first-word fall-through).
// Used for the {IR, PC} instruction queue and for the in-order PC tag queue.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push_i     : write wdata_i (ignored when full unless popping same cycle)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the FIFO; wins over push/pop in the same cycle
//   wdata_i    : entry to write
//   rdata_o    : head entry (don't-care while empty)
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : number of valid entries
// -----------------------------------------------------------------------------
module if_inst_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so a non-power-of-two depth still works.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still accept a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Producers size their traffic so a write never lands on a full FIFO.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push_i && full_o && !flush_i)
    );

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage, producer side of the IF/ID pipeline register.
// Generates the fetch PC, issues imem requests, queues returned words and
// presents {IR, PC, valid} to ID; honours the ID stall and branch redirect.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   imem        : instruction-memory bus (master side)
//   stall       : ID cannot accept; head of queue is held
//   redirect    : taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc : redirect target, bits [1:0] ignored
//   if_valid    : IR_out/PC_out carry a real instruction
//   IR_out      : instruction word (NOP_IR when not valid)
//   PC_out      : address of IR_out (0 when not valid)
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              QDEPTH    = 2,
    parameter int              MAX_OUTST = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_unit_if.master    imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [ILEN-1:0]    IR_out,
    output logic [XLEN-1:0]    PC_out
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   discard_q, discard_d;

    // Tag FIFO: PC of each outstanding request; its occupancy is the
    // outstanding-request count.
    logic [XLEN-1:0] tag_pc;
    logic            tag_full, tag_empty;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   outst_nxt;

    // Instruction queue.
    fetch_entry_t    q_wdata, q_head;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;

    logic            req, gnt_fire, rsp;
    logic [31:0]     occupancy;

    // Every issued request reserves a queue slot until its word is popped,
    // so a response can never find the queue full.
    assign occupancy = 32'(q_count) + 32'(outst);
    assign req       = (state_q == FETCH) && !tag_full && !q_full &&
                       (occupancy < 32'(QDEPTH));
    assign gnt_fire  = req && imem.imem_gnt;
    assign rsp       = imem.imem_rvalid && !tag_empty;
    assign outst_nxt = outst + OW'(gnt_fire) - OW'(rsp);

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;

    // A word arriving in the redirect cycle is already counted as stale.
    assign q_push        = rsp && (discard_q == '0) && !redirect;
    assign q_pop         = !q_empty && !stall && !redirect;
    assign q_wdata.ir    = imem.imem_rdata;
    assign q_wdata.pc    = tag_pc;

    // Tags are never flushed: stale responses still pop their own tag, which
    // keeps later tags aligned with later responses.
    if_inst_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (gnt_fire),
        .pop_i   (rsp),
        .flush_i (1'b0),
        .wdata_i (fetch_pc_q),
        .rdata_o (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (outst)
    );

    if_inst_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign if_valid = !q_empty;
    assign IR_out   = q_empty ? NOP_IR   : q_head.ir;
    assign PC_out   = q_empty ? XLEN'(0) : q_head.pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   state_d = (discard_d == '0) ? FETCH : DRAIN;
            default: state_d = FETCH;
        endcase

        // Every request still in flight after this edge, including one
        // granted right now, belongs to the old path.
        if (redirect) begin
            fetch_pc_d = align_word(redirect_pc);
            discard_d  = outst_nxt;
            state_d    = (outst_nxt != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. u_dut (QDEPTH=4) follows a hand-traced
// cycle table covering streaming, stall back-pressure, redirect with late
// responses, redirect coinciding with a grant and grant starvation. u_wrap
// (default depths, RESET_PC near the top of memory) free-runs to check PC
// wrap-around. A final sequence resets mid-burst with the queue full.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_unit_if bus  ();
    if_fetch_unit_if bus2 ();

    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] IR_out, PC_out;

    logic        stall2, redirect2;
    logic [31:0] redirect_pc2;
    logic        if_valid2;
    logic [31:0] IR_out2, PC_out2;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .QDEPTH    (4),
        .MAX_OUTST (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .IR_out      (IR_out),
        .PC_out      (PC_out)
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus2),
        .stall       (stall2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .if_valid    (if_valid2),
        .IR_out      (IR_out2),
        .PC_out      (PC_out2)
    );

    typedef struct {
        logic        gnt;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        rsp;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC = 36;
    vec_t        vt [NVEC];
    logic [31:0] pend  [$];
    logic [31:0] pend2 [$];
    logic [31:0] wrap_pc [3];
    logic [31:0] wrap_ir [3];
    int          nw;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic g, input logic s, input logic r,
                                input logic [31:0] rpc, input logic rsp,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc);
        vec_t v;
        v.gnt = g; v.stl = s; v.rdr = r; v.rpc = rpc; v.rsp = rsp;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs (memory responses from the bench's pending
    // queues), let the edge happen, record grants, return at the next negedge.
    task automatic cycle(input logic g, input logic s, input logic r,
                         input logic [31:0] rpc, input logic rsp);
        logic        acc, acc2;
        logic [31:0] a, a2;
        if (rsp && pend.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        if (pend2.size() > 0) begin
            bus2.imem_rvalid = 1'b1;
            bus2.imem_rdata  = mem_word(pend2.pop_front());
        end else begin
            bus2.imem_rvalid = 1'b0;
            bus2.imem_rdata  = 32'h0;
        end
        bus.imem_gnt  = g;
        bus2.imem_gnt = 1'b1;
        stall         = s;
        redirect      = r;
        redirect_pc   = rpc;
        #1;
        acc  = bus.imem_req && g;
        a    = bus.imem_addr;
        acc2 = bus2.imem_req;
        a2   = bus2.imem_addr;
        @(posedge clk);
        #1;
        if (acc)  pend.push_back(a);
        if (acc2) pend2.push_back(a2);
        if (if_valid2 && nw < 3) begin
            wrap_pc[nw] = PC_out2;
            wrap_ir[nw] = IR_out2;
            nw++;
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; nw = 0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
        bus.imem_gnt = 1'b0;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = 32'h0;
        bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        //           gnt stl rdr rpc           rsp  req addr          vld pc
        vt[0]  = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0000, L, 32'h0);
        vt[1]  = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0004, L, 32'h0);
        vt[2]  = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0008, H, 32'h0000_0000);
        vt[3]  = mk(H, L, L, 32'h0,        H,   H, 32'h0000_000C, H, 32'h0000_0004);
        vt[4]  = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0010, H, 32'h0000_0008);
        vt[5]  = mk(H, H, L, 32'h0,        H,   H, 32'h0000_0014, H, 32'h0000_0008);
        vt[6]  = mk(H, H, L, 32'h0,        H,   L, 32'h0000_0018, H, 32'h0000_0008);
        vt[7]  = mk(H, H, L, 32'h0,        H,   L, 32'h0000_0018, H, 32'h0000_0008);
        vt[8]  = mk(H, H, L, 32'h0,        H,   L, 32'h0000_0018, H, 32'h0000_0008);
        vt[9]  = mk(H, H, L, 32'h0,        H,   L, 32'h0000_0018, H, 32'h0000_0008);
        vt[10] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0018, H, 32'h0000_000C);
        vt[11] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_001C, H, 32'h0000_0010);
        vt[12] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0020, H, 32'h0000_0014);
        vt[13] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0024, H, 32'h0000_0018);
        vt[14] = mk(H, L, L, 32'h0,        L,   L, 32'h0000_0028, H, 32'h0000_001C);
        vt[15] = mk(H, L, H, 32'h0000_0103, L,  L, 32'h0000_0100, L, 32'h0);
        vt[16] = mk(H, L, L, 32'h0,        H,   L, 32'h0000_0100, L, 32'h0);
        vt[17] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0100, L, 32'h0);
        vt[18] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0104, L, 32'h0);
        vt[19] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0108, H, 32'h0000_0100);
        vt[20] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_010C, H, 32'h0000_0104);
        vt[21] = mk(H, L, H, 32'h0000_0200, L,  L, 32'h0000_0200, L, 32'h0);
        vt[22] = mk(H, L, L, 32'h0,        H,   L, 32'h0000_0200, L, 32'h0);
        vt[23] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0200, L, 32'h0);
        vt[24] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0204, L, 32'h0);
        vt[25] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0208, H, 32'h0000_0200);
        vt[26] = mk(L, L, L, 32'h0,        H,   H, 32'h0000_0208, H, 32'h0000_0204);
        vt[27] = mk(L, L, L, 32'h0,        H,   H, 32'h0000_0208, L, 32'h0);
        vt[28] = mk(L, L, L, 32'h0,        H,   H, 32'h0000_0208, L, 32'h0);
        vt[29] = mk(L, L, L, 32'h0,        H,   H, 32'h0000_0208, L, 32'h0);
        vt[30] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_020C, L, 32'h0);
        vt[31] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0210, H, 32'h0000_0208);
        vt[32] = mk(H, L, L, 32'h0,        H,   H, 32'h0000_0214, H, 32'h0000_020C);
        vt[33] = mk(H, H, L, 32'h0,        H,   H, 32'h0000_0218, H, 32'h0000_020C);
        vt[34] = mk(H, H, L, 32'h0,        H,   L, 32'h0000_021C, H, 32'h0000_020C);
        vt[35] = mk(H, H, L, 32'h0,        H,   L, 32'h0000_021C, H, 32'h0000_020C);

        repeat (2) @(negedge clk);
        chk("reset req",   32'(bus.imem_req), 32'h0);
        chk("reset addr",  bus.imem_addr,     32'h0);
        chk("reset valid", 32'(if_valid),     32'h0);
        chk("reset IR",    IR_out,            32'h0);
        chk("reset PC",    PC_out,            32'h0);
        chk("reset wrap addr", bus2.imem_addr, 32'hFFFF_FFF8);

        rst_n = 1'b1;
        #1;
        chk("boot req", 32'(bus.imem_req), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            cycle(vt[i].gnt, vt[i].stl, vt[i].rdr, vt[i].rpc, vt[i].rsp);
            chk($sformatf("row%0d req", i),   32'(bus.imem_req), 32'(vt[i].e_req));
            chk($sformatf("row%0d addr", i),  bus.imem_addr,     vt[i].e_addr);
            chk($sformatf("row%0d valid", i), 32'(if_valid),     32'(vt[i].e_vld));
            chk($sformatf("row%0d PC", i),    PC_out,            vt[i].e_pc);
            chk($sformatf("row%0d IR", i),    IR_out,
                vt[i].e_vld ? mem_word(vt[i].e_pc) : 32'h0);
        end

        // Mid-burst asynchronous reset with the queue full.
        chk("full before reset", 32'(if_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus2.imem_rvalid = 1'b0;
        stall = 1'b0;
        #1;
        chk("async reset req",   32'(bus.imem_req), 32'h0);
        chk("async reset addr",  bus.imem_addr,     32'h0);
        chk("async reset valid", 32'(if_valid),     32'h0);
        chk("async reset IR",    IR_out,            32'h0);
        chk("async reset PC",    PC_out,            32'h0);
        pend.delete();
        pend2.delete();
        @(negedge clk);
        chk("held reset valid", 32'(if_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("reboot req", 32'(bus.imem_req), 32'h0);
        cycle(H, L, L, 32'h0, H);
        chk("restart req",   32'(bus.imem_req), 32'h1);
        chk("restart addr",  bus.imem_addr,     32'h0);
        chk("restart valid", 32'(if_valid),     32'h0);
        cycle(H, L, L, 32'h0, H);
        chk("restart addr2", bus.imem_addr, 32'h4);
        cycle(H, L, L, 32'h0, H);
        chk("restart valid2", 32'(if_valid), 32'h1);
        chk("restart PC",     PC_out,        32'h0);
        chk("restart IR",     IR_out,        mem_word(32'h0));
        chk("restart addr3",  bus.imem_addr, 32'h8);

        // Wrap-around instance: first three delivered instructions.
        chk("wrap count", 32'(nw), 32'd3);
        chk("wrap pc0", wrap_pc[0], 32'hFFFF_FFF8);
        chk("wrap pc1", wrap_pc[1], 32'hFFFF_FFFC);
        chk("wrap pc2", wrap_pc[2], 32'h0000_0000);
        chk("wrap ir0", wrap_ir[0], mem_word(32'hFFFF_FFF8));
        chk("wrap ir2", wrap_ir[2], mem_word(32'h0000_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID pipeline register.
- Generates the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small queue and presents {IR, PC} plus a valid flag to the IF/ID register.
- Obeys the ID-side stall and the branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue entries (power of two, ≥2).
- MAX_OUTST, 2, maximum outstanding imem requests (≤ QDEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- stall  in  1  ID cannot accept; output must hold.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  target address, bits[1:0] ignored.
- if_valid  out  1  IR_out/PC_out hold a real instruction.
- IR_out  out  32  instruction to the IF/ID register.
- PC_out  out  32  address of IR_out.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, state=BOOT.
  - Outputs: imem_req=0, if_valid=0, IR_out=0, PC_out=0.
- FSM states:
  - BOOT: one cycle after reset release, no request; then FETCH.
  - FETCH: normal operation.
  - DRAIN: after a redirect while discard>0; no new requests; returns to FETCH once discard reaches 0 (including the cycle it reaches 0).
- Request issue: imem_req=1 in FETCH when outstanding < MAX_OUTST and (queue count + outstanding) < QDEPTH.
  - imem_addr=fetch_pc.
  - On gnt: fetch_pc += 4 and outstanding++.
  - imem_addr is stable while imem_req=1 and gnt=0, except on redirect.
- Response: on rvalid, outstanding--.
  - discard>0: decrement discard and drop the word.
  - Otherwise push {rdata, pc_of_request}; each request's PC is tracked in an in-order tag FIFO of depth MAX_OUTST.
- Output:
  - Queue head drives IR_out/PC_out/if_valid combinationally from registers.
  - Empty queue gives if_valid=0, IR_out=0, PC_out=0.
  - Pop when if_valid=1 and stall=0.
  - stall=1 holds head and outputs unchanged.
- Bypass: none. Latency from gnt with rvalid the next cycle is one additional cycle until if_valid.
- Redirect (highest priority, same cycle):
  - Queue cleared and if_valid=0 next cycle.
  - fetch_pc=redirect_pc&~3.
  - discard = outstanding minus responses arriving this cycle, plus 1 if a gnt occurs this cycle.
  - Any gnt in the redirect cycle counts as a stale request.
  - Next state is DRAIN if the new discard>0, else FETCH.
  - redirect overrides stall.
- Simultaneous push and pop in one cycle: count unchanged.
- Push when full: impossible by issue rule. Assertion required.
- Wrap-around:
  - fetch_pc 32'hFFFF_FFFC+4 wraps to 0 without error.
  - Queue pointers wrap modulo QDEPTH.
- Redirect during BOOT: accepted, with fetch target updated.
- Reset mid-operation drops everything immediately. Responses after reset for old requests are the memory's responsibility (it is reset too).

Decomposition:
- if_pkg:
  - NOP_IR (32'h0).
  - fetch_state_t enum {BOOT, FETCH, DRAIN}.
  - Width constants XLEN=32, ILEN=32.
- Sub-module if_inst_fifo: parameterized sync FIFO of {IR, PC}.
  - Ports push/pop/flush/full/empty/count.
  - Also instanced at depth MAX_OUTST for PC tags.

Test Plan:
- Reset release, imem_gnt=1 and rvalid one cycle after each gnt, stall=0 → first imem_req at cycle 2 with addr 0x0. if_valid rises with PC_out=0x0, then 0x4, 0x8 on consecutive cycles, no bubbles.
- Hold stall=1 for 5 cycles with PC_out=0x8 → IR_out/PC_out constant. Requests stop once count+outstanding=QDEPTH. Release stall → 0xC follows with no duplicates or skips.
- redirect=1 with redirect_pc=0x103 while 2 requests are outstanding → next cycle if_valid=0. The 2 late responses are dropped (state=DRAIN). First issued addr is 0x100, next valid PC_out=0x100.
- redirect and imem_gnt in the same cycle with outstanding=1 → discard=2. Both stale words are dropped, and the first delivered PC equals the target.
- imem_gnt held 0 for 4 cycles → imem_addr stable, if_valid=0 after the queue empties. Also cover a wrap test: RESET_PC=0xFFFF_FFF8 gives PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Assert rst_n=0 mid-burst with queue full → all outputs 0 immediately (asynchronous). After release, fetch restarts at RESET_PC.
